// File: rtl/branch_pkg.sv
// Shared types for branch resolution and the pattern history table.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package branch_pkg;

    // RV32I conditional-branch funct3 encodings; 010 and 011 are unused.
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_t;

    // 2-bit saturating direction counter; the MSB is the predicted direction.
    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t SNT = 2'b00;
    localparam bht_ctr_t WNT = 2'b01;
    localparam bht_ctr_t WT  = 2'b10;
    localparam bht_ctr_t ST  = 2'b11;

    localparam bht_ctr_t BHT_INIT = WNT;

    // Move one step toward the resolved direction, clamping at both ends.
    function automatic bht_ctr_t ctr_next(input bht_ctr_t cur, input logic taken);
        bht_ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = cur + 2'd1;
        end else begin
            if (cur != SNT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-side prediction and execute-side resolution signals of the branch unit.
// Latency: n/a (wiring only).
// Backpressure: none; the pipeline drives ex_valid low on bubbles and stalls.
interface branch_predict_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  fetch_pc;
    logic             predict_taken;
    logic             ex_valid;
    logic             ex_branch;
    logic [2:0]       ex_branch_type;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_target;
    logic             ex_pred_taken;
    logic             branch_taken;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    // Pipeline side: supplies PCs and operands, consumes prediction and redirect.
    modport master (
        output fetch_pc, ex_valid, ex_branch, ex_branch_type, ex_rs1, ex_rs2,
               ex_pc, ex_target, ex_pred_taken,
        input  predict_taken, branch_taken, mispredict, redirect_pc,
               branch_count, mispredict_count
    );

    // Branch unit side.
    modport slave (
        input  fetch_pc, ex_valid, ex_branch, ex_branch_type, ex_rs1, ex_rs2,
               ex_pc, ex_target, ex_pred_taken,
        output predict_taken, branch_taken, mispredict, redirect_pc,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_cond.sv
// Evaluates an RV32I conditional-branch condition from the two raw operands.
// Latency: purely combinational.
// Backpressure: none.
module branch_cond
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      br_type,
    output logic            cond,
    output logic            type_valid
);

    // Decode funct3 into the comparison result; reserved encodings never take.
    always_comb begin
        cond       = 1'b0;
        type_valid = 1'b1;
        case (br_type)
            BEQ:     cond = (rs1 == rs2);
            BNE:     cond = (rs1 != rs2);
            BLT:     cond = ($signed(rs1) <  $signed(rs2));
            BGE:     cond = ($signed(rs1) >= $signed(rs2));
            BLTU:    cond = (rs1 <  rs2);
            BGEU:    cond = (rs1 >= rs2);
            default: type_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped 2-bit PHT prediction at fetch plus branch resolution at execute.
// Latency: prediction and resolve outputs combinational; PHT/stats update next edge.
// Backpressure: none; a low ex_valid slot is simply ignored.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predict_unit_if.slave bus
);

    localparam int IDX_W = $clog2(ENTRIES);

    bht_ctr_t         pht [ENTRIES];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             cond;
    logic             type_valid;
    logic             res;
    logic             taken;
    logic             mispred;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;
    logic             unused_pc_bits;

    branch_cond #(.XLEN(XLEN)) u_cond (
        .rs1        (bus.ex_rs1),
        .rs2        (bus.ex_rs2),
        .br_type    (bus.ex_branch_type),
        .cond       (cond),
        .type_valid (type_valid)
    );

    // Word-aligned PCs: drop the byte offset, keep the low IDX_W word bits.
    assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
    assign ex_idx    = bus.ex_pc[IDX_W+1:2];

    // Upper PC bits and byte offset do not participate in indexing.
    assign unused_pc_bits = ^{bus.fetch_pc[XLEN-1:IDX_W+2], bus.fetch_pc[1:0],
                              bus.ex_pc[XLEN-1:IDX_W+2], bus.ex_pc[1:0]};

    assign res     = bus.ex_valid & bus.ex_branch & type_valid;
    assign taken   = res & cond;
    assign mispred = res & (cond != bus.ex_pred_taken);

    // Read straight from the array: a same-cycle update is not bypassed.
    assign bus.predict_taken    = pht[fetch_idx][1];
    assign bus.branch_taken     = taken;
    assign bus.mispredict       = mispred;
    assign bus.redirect_pc      = taken ? bus.ex_target : (bus.ex_pc + XLEN'(4));
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispred_cnt_q;

    // Train the resolved entry and bump statistics; reset wins over any resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) pht[i] <= BHT_INIT;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (res) begin
            pht[ex_idx]  <= ctr_next(pht[ex_idx], cond);
            branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (mispred) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized and directed checks of branch_predict_unit against a behavioural model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_branch_predict_unit;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int CNT_W   = 32;

    logic clk;
    logic rst;

    branch_predict_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_predict_unit #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: one plain integer counter (0..3) per table entry.
    int          pht_m [ENTRIES];
    logic [31:0] bcnt_m;
    logic [31:0] mcnt_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_m(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic type_ok_m(input logic [2:0] t);
        return !(t == 3'd2 || t == 3'd3);
    endfunction

    function automatic logic cond_m(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        case (t)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) pht_m[i] = 1;
        bcnt_m = 0;
        mcnt_m = 0;
    endtask

    // Apply one execute slot plus a fetch PC, check combinational outputs,
    // cross the clock edge, then check the committed state.
    task automatic do_cycle(input logic v, input logic b, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] bb,
                            input logic [31:0] pc, input logic [31:0] tgt,
                            input logic pd, input logic [31:0] fpc);
        logic res_e;
        logic cond_e;
        logic take_e;
        logic mis_e;
        logic [31:0] next_e;
        int ei;
        bus.fetch_pc       = fpc;
        bus.ex_valid       = v;
        bus.ex_branch      = b;
        bus.ex_branch_type = t;
        bus.ex_rs1         = a;
        bus.ex_rs2         = bb;
        bus.ex_pc          = pc;
        bus.ex_target      = tgt;
        bus.ex_pred_taken  = pd;
        #2;
        cond_e = cond_m(t, a, bb);
        res_e  = v && b && type_ok_m(t);
        take_e = res_e && cond_e;
        mis_e  = res_e && (cond_e != pd);
        next_e = pc + 32'd4;
        ei     = idx_m(pc);
        check("predict_taken", 64'(bus.predict_taken), 64'(pht_m[idx_m(fpc)] >= 2));
        check("branch_taken", 64'(bus.branch_taken), 64'(take_e));
        check("mispredict", 64'(bus.mispredict), 64'(mis_e));
        if (mis_e) check("redirect_pc", 64'(bus.redirect_pc), 64'(take_e ? tgt : next_e));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (res_e) begin
            if (cond_e && pht_m[ei] < 3) pht_m[ei]++;
            if (!cond_e && pht_m[ei] > 0) pht_m[ei]--;
            bcnt_m++;
            if (mis_e) mcnt_m++;
        end
        #1;
        check("branch_count", 64'(bus.branch_count), 64'(bcnt_m));
        check("mispredict_count", 64'(bus.mispredict_count), 64'(mcnt_m));
        check("pht_entry", 64'(dut.pht[ei]), 64'(pht_m[ei]));
    endtask

    task automatic bubble(input logic [31:0] fpc);
        do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h0, 32'h0, 1'b0, fpc);
    endtask

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_pc;
    logic [31:0] r_fpc;

    initial begin
        rst = 1'b1;
        bus.fetch_pc = '0; bus.ex_valid = 0; bus.ex_branch = 0; bus.ex_branch_type = '0;
        bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_pc = '0; bus.ex_target = '0;
        bus.ex_pred_taken = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Reset state.
        bus.fetch_pc = 32'h100;
        #1;
        check("reset_predict", 64'(bus.predict_taken), 64'd0);
        check("reset_branch_count", 64'(bus.branch_count), 64'd0);
        check("reset_mispredict_count", 64'(bus.mispredict_count), 64'd0);

        // Signed vs unsigned comparison of the same operands.
        do_cycle(1, 1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h80, 1'b0, 32'h100);
        bubble(32'h100);
        check("blt_trained_predict", 64'(bus.predict_taken), 64'd1);
        do_cycle(1, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h80, 1'b1, 32'h100);
        do_cycle(1, 1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h80, 1'b0, 32'h100);

        // Saturation at both ends.
        for (int i = 0; i < 5; i++)
            do_cycle(1, 1, 3'b000, 32'd5, 32'd5, 32'h40, 32'h10, 1'b0, 32'h40);
        for (int i = 0; i < 4; i++)
            do_cycle(1, 1, 3'b000, 32'd5, 32'd6, 32'h40, 32'h10, 1'b1, 32'h40);

        // Reserved type and bubble slot leave everything untouched.
        do_cycle(1, 1, 3'b010, 32'd5, 32'd5, 32'h100, 32'h10, 1'b0, 32'h100);
        do_cycle(1, 1, 3'b011, 32'd5, 32'd5, 32'h100, 32'h10, 1'b0, 32'h100);
        do_cycle(0, 1, 3'b000, 32'd5, 32'd5, 32'h100, 32'h10, 1'b0, 32'h100);

        // A resolve that coincides with reset is dropped.
        rst = 1'b1;
        do_cycle(1, 1, 3'b000, 32'd7, 32'd7, 32'h300, 32'h20, 1'b0, 32'h300);
        rst = 1'b0;
        check("midreset_pht", 64'(dut.pht[0]), 64'd1);

        // Same-index fetch and resolve: old value now, new value next cycle.
        do_cycle(1, 1, 3'b000, 32'd9, 32'd9, 32'h200, 32'h400, 1'b0, 32'h200);
        bubble(32'h200);

        // Randomized traffic over a few PC aliases, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 2) == 0) ? r_a : $urandom;
            if ($urandom_range(0, 3) == 0) r_b = {~r_a[31], r_a[30:0]};
            r_pc = ($urandom_range(0, 15) << 28) | ($urandom_range(0, 255) << 2);
            r_fpc = ($urandom_range(0, 1) == 0) ? r_pc
                  : (($urandom_range(0, 15) << 28) | ($urandom_range(0, 255) << 2));
            rst = ($urandom_range(0, 60) == 0);
            do_cycle(logic'($urandom_range(0, 5) != 0), logic'($urandom_range(0, 5) != 0),
                     3'($urandom_range(0, 7)), r_a, r_b, r_pc, $urandom,
                     logic'($urandom_range(0, 1)), r_fpc);
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Execute-stage branch resolution plus a fetch-stage direct-mapped pattern history table (PHT) of 2-bit saturating counters.
- Compares its own XLEN-wide operands, so it does not depend on the ALU zero flag or result LSB.
- Resolves all six RV32I conditional branches and flags mispredictions against the fetch-time prediction.
- Supplies the corrected PC and keeps branch and mispredict statistics counters.

Parameters:
- XLEN, 32, operand/PC width.
- ENTRIES, 64, PHT depth; must be a power of two, minimum 2.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- fetch_pc  in  XLEN  PC being fetched.
- predict_taken  out  1  prediction for fetch_pc.
- ex_valid  in  1  execute-stage slot holds a live instruction (low on bubble/stall).
- ex_branch  in  1  instruction is a conditional branch.
- ex_branch_type  in  3  funct3 branch encoding.
- ex_rs1, ex_rs2  in  XLEN  comparison operands.
- ex_pc  in  XLEN  branch PC.
- ex_target  in  XLEN  computed branch target.
- ex_pred_taken  in  1  prediction carried down the pipe from fetch.
- branch_taken  out  1  resolved outcome.
- mispredict  out  1  outcome differs from prediction.
- redirect_pc  out  XLEN  correct next PC.
- branch_count  out  CNT_W  resolved branches since reset.
- mispredict_count  out  CNT_W  mispredictions since reset.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. Everything resets on the edge where rst=1.
- Index: idx = pc[IDX_W+1:2], where IDX_W = $clog2(ENTRIES). The same mapping applies to fetch_pc and ex_pc.
- predict_taken: combinational, equal to PHT[idx(fetch_pc)][1]. Zero-cycle latency from the current array state.
- Branch conditions, evaluated combinationally:
  - BEQ 000: rs1==rs2
  - BNE 001: rs1!=rs2
  - BLT 100: signed rs1<rs2
  - BGE 101: signed rs1>=rs2
  - BLTU 110: unsigned rs1<rs2
  - BGEU 111: unsigned rs1>=rs2
  - 010 and 011 are invalid: cond=0.
- Resolve qualifier: res = ex_valid & ex_branch & valid_type(ex_branch_type).
- Combinational outputs:
  - branch_taken = res & cond.
  - mispredict = res & (cond != ex_pred_taken).
  - redirect_pc = branch_taken ? ex_target : ex_pc + 4, with the +4 computed modulo 2^XLEN.
  - redirect_pc is meaningful only when mispredict=1.
- PHT update, registered on the edge where res=1:
  - Counter at idx(ex_pc) saturating-increments when cond=1, saturating-decrements when cond=0.
  - Saturation: 11 stays 11 on taken; 00 stays 00 on not-taken.
  - Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Same-cycle hazard: when fetch and resolve hit the same index in one cycle, predict_taken returns the pre-update value. There is no bypass; the update is visible from the next cycle.
- No update cases: ex_valid=0, ex_branch=0, or an invalid type cause no PHT or counter change, and branch_taken, mispredict and redirect validity are all 0.
- Statistics:
  - branch_count increments on every res=1 edge.
  - mispredict_count increments on every edge where mispredict=1.
  - Both wrap modulo 2^CNT_W; no saturation.
- Reset values:
  - All PHT entries become 01 (weak-NT), so predict_taken=0 after reset.
  - branch_count and mispredict_count become 0.
  - Combinational outputs follow their inputs during reset, but no update is committed while rst=1. This includes a resolve that is in flight mid-reset, which is dropped.

Decomposition:
- Package branch_pkg holds:
  - branch_t enum (BEQ..BGEU, 3-bit).
  - bht_ctr_t 2-bit counter type with constants SNT, WNT, WT, ST.
  - Reset constant BHT_INIT = WNT.
- One sub-module, branch_cond: pure combinational. Inputs rs1, rs2, type; outputs cond and type_valid; parametrised by XLEN.
- The PHT array, counters and statistics live in the top module.

Test Plan:
- Reset, then fetch_pc=0x100 -> predict_taken=0; branch_count=0; mispredict_count=0.
- BLT with rs1=0xFFFFFFFF, rs2=1, pred 0, pc=0x100, target=0x80 -> branch_taken=1, mispredict=1, redirect_pc=0x80. Next cycle PHT[0]=10, predict_taken(0x100)=1, mispredict_count=1.
- BLTU with the same operands, pred 1 -> taken=0, mispredict=1, redirect_pc=0x104. Then BGEU with the same operands -> taken=1.
- Saturation: four taken BEQ (rs1=rs2=5) at pc 0x40 -> counter 11; a fifth stays 11. Three not-taken then reach 00, and a further one stays 00.
- Invalid or bubble: type 010 with ex_branch=1, and separately ex_valid=0 -> no PHT change, counts unchanged, mispredict=0.
- Same-index collision: fetch_pc=ex_pc=0x200 with a taken resolve from WNT -> predict_taken=0 that cycle and 1 the next. Also: assert rst during a resolve -> no counter change, PHT entry stays 01.
